// File: rtl/channel_pkt_buffer.sv
// Packet buffer: 2^PKT_LOG2 slots of 128 x 32-bit words, one writer and one
// reader on txclk.
// Ports: txclk, reset (sync, active-high); write side WR, ram_data, WR_done;
// read side RD, RD_done, dataout (registered); status have_space,
// packet_waiting, overflow_count.
// Define CHAN_BUF_OVERFLOW_CNT_EN to build the dropped-word counter;
// otherwise overflow_count is tied to zero.
module channel_pkt_buffer #(
  parameter int PKT_LOG2 = 2
) (
  input  logic        txclk,
  input  logic        reset,
  input  logic        WR,
  input  logic [31:0] ram_data,
  input  logic        WR_done,
  input  logic        RD,
  input  logic        RD_done,
  output logic [31:0] dataout,
  output logic        have_space,
  output logic        packet_waiting,
  output logic [15:0] overflow_count
);

  localparam int NSLOT = 1 << PKT_LOG2;
  localparam int CW    = PKT_LOG2 + 1;

  logic [31:0] mem [NSLOT*128];

  logic [PKT_LOG2-1:0] wr_slot_q, wr_slot_d;
  logic [PKT_LOG2-1:0] rd_slot_q, rd_slot_d;
  logic [6:0]          wr_word_q, wr_word_d;
  logic [6:0]          rd_word_q, rd_word_d;
  logic [CW-1:0]       pkt_cnt_q, pkt_cnt_d;
  logic [31:0]         dataout_q, dataout_d;

  logic wr_en;
  logic rd_en;
  logic commit;
  logic rel;

  assign have_space     = pkt_cnt_q < CW'(NSLOT);
  assign packet_waiting = pkt_cnt_q != '0;
  assign dataout        = dataout_q;

  assign wr_en = WR & have_space;
  assign rd_en = RD & packet_waiting;
  assign rel   = RD_done & packet_waiting;

  // A WR_done on an empty packet is dropped; a WR_done together with the
  // 128th write collapses into the single auto-commit.
  assign commit = have_space &
                  ((WR & (wr_word_q == 7'd127)) |
                   (WR_done & (WR | (wr_word_q != 7'd0))));

  always_comb begin
    wr_slot_d = wr_slot_q;
    wr_word_d = wr_word_q;
    rd_slot_d = rd_slot_q;
    rd_word_d = rd_word_q;
    pkt_cnt_d = pkt_cnt_q;
    dataout_d = dataout_q;
    if (wr_en) wr_word_d = wr_word_q + 7'd1;
    if (commit) begin
      wr_word_d = '0;
      wr_slot_d = wr_slot_q + PKT_LOG2'(1);
    end
    if (rd_en) begin
      dataout_d = mem[{rd_slot_q, rd_word_q}];
      rd_word_d = rd_word_q + 7'd1;
    end
    if (rel) begin
      rd_word_d = '0;
      rd_slot_d = rd_slot_q + PKT_LOG2'(1);
    end
    unique case ({commit, rel})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge txclk) begin
    if (reset) begin
      wr_slot_q <= '0;
      wr_word_q <= '0;
      rd_slot_q <= '0;
      rd_word_q <= '0;
      pkt_cnt_q <= '0;
      dataout_q <= '0;
    end else begin
      wr_slot_q <= wr_slot_d;
      wr_word_q <= wr_word_d;
      rd_slot_q <= rd_slot_d;
      rd_word_q <= rd_word_d;
      pkt_cnt_q <= pkt_cnt_d;
      dataout_q <= dataout_d;
    end
  end

  // Storage has no reset; a write coinciding with reset is discarded.
  always_ff @(posedge txclk) begin
    if (!reset && wr_en) mem[{wr_slot_q, wr_word_q}] <= ram_data;
  end

`ifdef CHAN_BUF_OVERFLOW_CNT_EN
  logic [15:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (WR && !have_space && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge txclk) begin
    if (reset) ovf_q <= '0;
    else       ovf_q <= ovf_d;
  end

  assign overflow_count = ovf_q;
`else
  assign overflow_count = 16'd0;
`endif

endmodule

// File: tb/tb_channel_pkt_buffer.sv
// Testbench for channel_pkt_buffer: directed scenarios plus random traffic
// against a packet-queue reference model.
module tb_channel_pkt_buffer;

  localparam int NSLOT = 4;

  logic        txclk = 1'b0;
  logic        reset = 1'b1;
  logic        WR = 1'b0;
  logic [31:0] ram_data = '0;
  logic        WR_done = 1'b0;
  logic        RD = 1'b0;
  logic        RD_done = 1'b0;
  logic [31:0] dataout;
  logic        have_space;
  logic        packet_waiting;
  logic [15:0] overflow_count;

  channel_pkt_buffer #(.PKT_LOG2(2)) dut (
    .txclk          (txclk),
    .reset          (reset),
    .WR             (WR),
    .ram_data       (ram_data),
    .WR_done        (WR_done),
    .RD             (RD),
    .RD_done        (RD_done),
    .dataout        (dataout),
    .have_space     (have_space),
    .packet_waiting (packet_waiting),
    .overflow_count (overflow_count)
  );

  always #5 txclk = ~txclk;

  // Model: committed words in order, lengths of committed packets,
  // the packet being written, and the read offset into the front packet.
  logic [31:0] cq[$];
  int          lens[$];
  logic [31:0] cur[$];
  int          ridx;
  logic [31:0] exp_dout;
  logic [15:0] exp_ovf;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic r, input logic w, input logic [31:0] d,
                       input logic wd, input logic rr, input logic rdn);
    bit space, waiting;
    if (r) begin
      cq.delete(); lens.delete(); cur.delete();
      ridx = 0; exp_dout = '0; exp_ovf = '0;
      return;
    end
    space   = lens.size() < NSLOT;
    waiting = lens.size() != 0;
    if (w) begin
      if (space) cur.push_back(d);
`ifdef CHAN_BUF_OVERFLOW_CNT_EN
      else if (exp_ovf != 16'hFFFF) exp_ovf++;
`endif
    end
    if (space && cur.size() > 0 && (cur.size() == 128 || wd)) begin
      foreach (cur[i]) cq.push_back(cur[i]);
      lens.push_back(cur.size());
      cur.delete();
    end
    if (rr && waiting) begin
      exp_dout = cq[ridx];
      ridx++;
    end
    if (rdn && waiting) begin
      for (int i = 0; i < lens[0]; i++) void'(cq.pop_front());
      void'(lens.pop_front());
      ridx = 0;
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [31:0] d,
                      input logic wd, input logic rr, input logic rdn);
    @(negedge txclk);
    reset = r; WR = w; ram_data = d; WR_done = wd; RD = rr; RD_done = rdn;
    model(r, w, d, wd, rr, rdn);
    @(posedge txclk);
    #1;
    chk("dataout", dataout, exp_dout);
    chk("have_space", 32'(have_space), 32'(lens.size() < NSLOT));
    chk("pkt_waiting", 32'(packet_waiting), 32'(lens.size() != 0));
    chk("ovf_count", 32'(overflow_count), 32'(exp_ovf));
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, 0);
  endtask

  task automatic write_pkt(input int n, input logic [31:0] base, input bit done);
    for (int i = 0; i < n; i++) step(0, 1, base + 32'(i), 0, 0, 0);
    if (done) step(0, 0, '0, 1, 0, 0);
  endtask

  task automatic read_pkt(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 1, 0);
    step(0, 0, '0, 0, 0, 1);
  endtask

  initial begin
    step(1, 1, 32'hDEAD, 1, 1, 1);
    step(1, 0, '0, 0, 0, 0);
    chk("rst_dout", dataout, 32'd0);
    chk("rst_space", 32'(have_space), 32'd1);
    chk("rst_wait", 32'(packet_waiting), 32'd0);

    // Auto-commit on 128th word, latency-1 reads.
    write_pkt(128, 32'd0, 0);
    chk("auto_commit", 32'(packet_waiting), 32'd1);
    read_pkt(128);
    chk("released", 32'(packet_waiting), 32'd0);

    // Explicit commit, empty WR_done ignored.
    step(0, 0, '0, 1, 0, 0);
    chk("empty_done", 32'(packet_waiting), 32'd0);
    write_pkt(10, 32'h1000, 1);
    read_pkt(10);
    write_pkt(5, 32'h2000, 1);
    read_pkt(5);

    // Fill all slots, then overflow.
    for (int p = 0; p < NSLOT; p++) write_pkt(128, 32'(p) << 16, 0);
    chk("full", 32'(have_space), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 32'hBAD0 + 32'(i), 0, 0, 0);
    step(0, 0, '0, 1, 0, 0);
`ifdef CHAN_BUF_OVERFLOW_CNT_EN
    chk("ovf5", 32'(overflow_count), 32'd5);
`else
    chk("ovf0", 32'(overflow_count), 32'd0);
`endif
    for (int p = 0; p < NSLOT; p++) read_pkt(128);

    // Commit and release in the same cycle with two packets held.
    write_pkt(7, 32'h3000, 1);
    write_pkt(9, 32'h4000, 1);
    write_pkt(3, 32'h5000, 0);
    step(0, 1, 32'h5003, 1, 0, 1);
    chk("cnt_hold", 32'(lens.size()), 32'd2);
    read_pkt(9);
    read_pkt(4);

    // Reset mid-packet.
    write_pkt(50, 32'h6000, 0);
    step(1, 1, 32'h6032, 0, 0, 0);
    chk("mid_rst_wait", 32'(packet_waiting), 32'd0);
    write_pkt(128, 32'h7000, 0);
    read_pkt(128);

    // Random traffic.
    for (int c = 0; c < 6000; c++) begin
      logic r, w, wd, rr, rdn;
      r   = ($urandom % 500) == 0;
      w   = $urandom % 2;
      wd  = ($urandom % 12) == 0;
      rr  = 0;
      rdn = 0;
      if (lens.size() == 0) begin
        rr  = $urandom % 2;
        rdn = $urandom % 2;
      end else if (ridx < lens[0]) begin
        rr  = ($urandom % 4) != 0;
        rdn = ($urandom % 100) == 0;
      end else begin
        rdn = ($urandom % 3) == 0;
      end
      step(r, w, $urandom, wd, rr, rdn);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
